// File: rtl/bcd_encoder.sv
// Sequential signed-binary to sign-magnitude BCD converter.
// An iterative double-dabble datapath handles one input bit per clock, with a start/done handshake.
module bcd_encoder #(
  parameter int IN_WIDTH = 11,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   binaryInput,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcdOutput,
  output logic                  overflow
);

  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(IN_WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0] LIMIT = pow10(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  logic [0:0]          state_q, state_d;
  logic                neg_q, neg_d;
  logic [IN_WIDTH-1:0] mag_q, mag_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       count_q, count_d;
  logic                sign_q, sign_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [IN_WIDTH-1:0] mag_in;
  logic [SW-1:0]       adj;
  logic [SW-1:0]       scratch_step;
  logic [31:0]         mag_wide;

  // The most negative input negates to itself, which read as unsigned is exactly its magnitude.
  assign mag_in   = binaryInput[IN_WIDTH-1] ? -binaryInput : binaryInput;
  assign mag_wide = 32'(mag_q);

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_step = SW'({adj, shift_q[IN_WIDTH-1]});
  end

  // NOTE: every _d gets a default first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    mag_d     = mag_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d     = binaryInput[IN_WIDTH-1];
          mag_d     = mag_in;
          shift_d   = mag_in;
          scratch_d = '0;
          count_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_step;
        shift_d   = shift_q << 1;
        count_d   = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = IDLE;
          sign_d  = neg_q;
          done_d  = 1'b1;
          if (mag_wide >= LIMIT) begin
            bcd_d = {DIGITS{4'h9}};
            ovf_d = 1'b1;
          end else begin
            bcd_d = scratch_step[4*DIGITS-1:0];
            ovf_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      mag_q     <= mag_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign sign      = sign_q;
  assign bcdOutput = bcd_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_encoder.sv
// Testbench for bcd_encoder: a transaction-level reference model checks all outputs every cycle.
// Directed vectors with hand-computed results pin both the model and the DUT.
module tb_bcd_encoder;
  localparam int IN_WIDTH = 11;
  localparam int DIGITS   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] bin = '0;
  logic        busy, done, sign, overflow;
  logic [11:0] bcd;

  bcd_encoder #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .binaryInput(bin),
    .busy(busy), .done(done), .sign(sign), .bcdOutput(bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  bit armed = 1'b0;

  bit          m_busy = 1'b0, m_done = 1'b0, m_sign = 1'b0, m_ovf = 1'b0;
  logic [11:0] m_bcd = '0;
  int          m_cnt = 0;
  int          m_val = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {sign, overflow, digits} from plain decimal arithmetic.
  function automatic logic [13:0] ref_out(input int v);
    int m;
    logic s;
    s = (v < 0);
    m = s ? -v : v;
    if (m > 999) return {s, 1'b1, 12'h999};
    return {s, 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Transaction model: a request accepted while idle completes IN_WIDTH edges later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      armed  <= 1'b1;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sign <= 1'b0;
      m_ovf  <= 1'b0;
      m_bcd  <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_sign, m_ovf, m_bcd} <= ref_out(m_val);
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= IN_WIDTH;
        m_val  <= int'($signed(bin));
      end
    end
  end

  always @(negedge clk) begin
    if (armed)
      check($sformatf("cyc%0d {busy,done,sign,ovf,bcd}", cyc),
            32'({busy, done, sign, overflow, bcd}),
            32'({m_busy, m_done, m_sign, m_ovf, m_bcd}));
  end

  assert property (@(posedge clk) disable iff (reset) !(busy && done))
    else $error("busy and done high together");
  assert property (@(posedge clk) disable iff (reset) (done && !start) |=> !done)
    else $error("done high two cycles without start held");

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input int v);
    start = 1'b1;
    bin   = 11'(v);
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic finish_conv(input string name, input logic [11:0] eb, input logic es, input logic eo);
    while (!done && (cyc - t0) < 30) @(negedge clk);
    check({name, " latency"}, 32'(cyc - t0), 32'(IN_WIDTH));
    check({name, " bcd"}, 32'(bcd), 32'(eb));
    check({name, " sign"}, 32'(sign), 32'(es));
    check({name, " ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    logic [13:0] r;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'(0));
    check("reset outs", 32'({done, sign, overflow, bcd}), 32'(0));

    launch(0);     finish_conv("zero", 12'h000, 1'b0, 1'b0);
    launch(999);   finish_conv("p999", 12'h999, 1'b0, 1'b0);
    launch(205);   finish_conv("p205", 12'h205, 1'b0, 1'b0);
    launch(-999);  finish_conv("n999", 12'h999, 1'b1, 1'b0);
    launch(-1);    finish_conv("n1", 12'h001, 1'b1, 1'b0);
    launch(1000);  finish_conv("p1000", 12'h999, 1'b0, 1'b1);
    launch(-1024); finish_conv("n1024", 12'h999, 1'b1, 1'b1);

    // A start pulse while busy is ignored; a start in the done cycle is taken.
    launch(123);
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin   = 11'd456;
    @(negedge clk);
    start = 1'b0;
    finish_conv("ignored456", 12'h123, 1'b0, 1'b0);
    launch(456);   finish_conv("b2b456", 12'h456, 1'b0, 1'b0);

    // Reset mid-conversion aborts without a done pulse.
    launch(777);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'(0));
    check("abort outs", 32'({done, sign, overflow, bcd}), 32'(0));
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("abort no done", 32'(done), 32'(0));
    end
    launch(42);    finish_conv("p42", 12'h042, 1'b0, 1'b0);

    // Start held high: conversions repeat back to back.
    start = 1'b1;
    bin   = 11'd5;
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);

    for (int v = -1024; v <= 1023; v++) begin
      @(negedge clk);
      launch(v);
      r = ref_out(v);
      finish_conv("sweep", r[11:0], r[13], r[12]);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
